seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_if.sv | 29 ++
 rtl/seven_seg_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - load/busy request channel of the seven-segment scanner
//
// Ports (signals):
//   value    [13:0]  unsigned magnitude to display
//   negative         sign of value, 1 = negative
//   load             single-cycle capture request
//   busy             conversion in progress
// Modports: master drives the request, slave (the scanner) answers busy.

interface seven_seg_scanner_if;
  logic [13:0] value;
  logic        negative;
  logic        load;
  logic        busy;

  modport master (
    output value,
    output negative,
    output load,
    input  busy
  );

  modport slave (
    input  value,
    input  negative,
    input  load,
    output busy
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - binary-to-BCD converter driving a 4-digit multiplexed 7-segment display
//
// Ports:
//   clk       in   system clock, every register updates on posedge
//   rst       in   synchronous active-high reset
//   slow_clk  in   scan-rate strobe from the clock divider, sampled as data
//   req       if   slave side of seven_seg_scanner_if (value, negative, load, busy)
//   an        out  [3:0] digit anodes, active-low one-hot, an[0] = units digit
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal point, active-low, permanently off
// Parameter:
//   BLANK_LZ  1 = blank leading zeros, 0 = show all four digits

module seven_seg_scanner #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      slow_clk,
  seven_seg_scanner_if.slave        req,
  output logic [3:0]                an,
  output logic [6:0]                seg,
  output logic                      dp
);

  // Digit codes held in the display registers: 0..9 are decimal digits,
  // two extra codes cover the minus sign and a dark digit.
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  // Display contents after reset: the value 0.
  localparam logic [15:0] DISP_RESET = BLANK_LZ ?
    {CODE_BLANK, CODE_BLANK, CODE_BLANK, 4'd0} : 16'h0000;

  localparam logic [3:0] LAST_SHIFT = 4'd13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic do_load;
  logic do_shift;
  logic do_commit;

  // Conversion datapath
  logic [13:0]      sh;        // captured magnitude, consumed MSB first
  logic             cap_neg;   // captured sign
  logic [3:0]       cnt;       // shift cycles completed
  logic [15:0]      bcd;       // four BCD nibbles, nibble 3 = thousands
  logic [15:0]      bcd_adj;   // bcd after the add-3 correction
  logic             carry;     // a 1 has been shifted out of the thousands nibble

  // Display and scan state
  logic [3:0][3:0]  disp;      // digit codes, disp[0] = units
  logic [3:0][3:0]  disp_new;  // digit codes produced by the finished conversion
  logic [3:0][3:0]  disp_next; // what disp holds after this edge
  logic             ovf;
  logic             slow_q;
  logic             primed;
  logic             rise;
  logic [1:0]       idx;
  logic [1:0]       idx_next;

  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:      s = 7'h40;
      4'd1:      s = 7'h79;
      4'd2:      s = 7'h24;
      4'd3:      s = 7'h30;
      4'd4:      s = 7'h19;
      4'd5:      s = 7'h12;
      4'd6:      s = 7'h02;
      4'd7:      s = 7'h78;
      4'd8:      s = 7'h00;
      4'd9:      s = 7'h10;
      CODE_DASH: s = 7'h3F;
      default:   s = 7'h7F;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (req.load) begin
          do_load    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (cnt == LAST_SHIFT) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        do_commit  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Busy covers the SHIFT and COMMIT cycles; load is only accepted in IDLE,
  // so requests arriving while busy never reach the captured operands.
  assign req.busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Double-dabble datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh      <= '0;
      cap_neg <= 1'b0;
      cnt     <= '0;
      bcd     <= '0;
      carry   <= 1'b0;
    end else if (do_load) begin
      sh      <= req.value;
      cap_neg <= req.negative;
      cnt     <= '0;
      bcd     <= '0;
      carry   <= 1'b0;
    end else if (do_shift) begin
      bcd     <= {bcd_adj[14:0], sh[13]};
      sh      <= {sh[12:0], 1'b0};
      cnt     <= cnt + 4'd1;
      // Anything pushed past the thousands nibble means the magnitude
      // needs a fifth digit, i.e. it exceeds 9999.
      carry   <= carry | bcd_adj[15];
    end
  end

  // ---------------------------------------------------------------------------
  // Digit formatting: overflow dashes, sign, leading-zero blanking
  // ---------------------------------------------------------------------------
  // A negative number has only three digits of room, so a nonzero thousands
  // digit is already an overflow.
  assign ovf = carry | (cap_neg & (bcd[15:12] != 4'd0));

  always_comb begin
    disp_new = {bcd[15:12], bcd[11:8], bcd[7:4], bcd[3:0]};
    if (ovf) begin
      disp_new = {4{CODE_DASH}};
    end else if (cap_neg) begin
      disp_new[3] = CODE_DASH;
      if (BLANK_LZ && (bcd[11:8] == 4'd0)) begin
        disp_new[2] = CODE_BLANK;
        if (bcd[7:4] == 4'd0) begin
          disp_new[1] = CODE_BLANK;
        end
      end
    end else if (BLANK_LZ) begin
      if (bcd[15:12] == 4'd0) begin
        disp_new[3] = CODE_BLANK;
        if (bcd[11:8] == 4'd0) begin
          disp_new[2] = CODE_BLANK;
          if (bcd[7:4] == 4'd0) begin
            disp_new[1] = CODE_BLANK;
          end
        end
      end
    end
  end

  // All four digits switch together on the COMMIT edge.
  assign disp_next = do_commit ? disp_new : disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= DISP_RESET;
    end else begin
      disp <= disp_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan
  // ---------------------------------------------------------------------------
  // primed suppresses edge detection on the first cycle after reset, so a
  // slow_clk already high when reset releases is not mistaken for a new edge.
  assign rise     = primed & slow_clk & ~slow_q;
  assign idx_next = idx + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      slow_q <= 1'b0;
      primed <= 1'b0;
      idx    <= 2'd0;
      an     <= 4'b1110;
      seg    <= 7'h40;
    end else begin
      slow_q <= slow_clk;
      primed <= 1'b1;
      if (rise) begin
        idx <= idx_next;
        an  <= ~(4'b0001 << idx_next);
        // disp_next so a scan edge landing on COMMIT already shows new data
        seg <= seg_encode(disp_next[idx_next]);
      end
    end
  end

  assign dp = 1'b1;

endmodule
